// File: rtl/ddr3_traffic_gen_if.sv
// rtl/ddr3_traffic_gen_if.sv - DDR3_manage user-side request bus between traffic generator (master) and manager (slave)
interface ddr3_traffic_gen_if #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 28
);
  logic              ddr3_rdy;
  logic              ddr3_write_req;
  logic              ddr3_read_req;
  logic [ADDR_W-1:0] ddr3_wr_addr;
  logic [ADDR_W-1:0] ddr3_rd_addr;
  logic              ddr3_write_done;
  logic              ddr3_read_done;
  logic              ddr3_wr_data_req;
  logic [DATA_W-1:0] ddr3_wr_data;
  logic              ddr3_rd_data_valid;
  logic [DATA_W-1:0] ddr3_rd_data;

  modport master (
    input  ddr3_rdy, ddr3_write_done, ddr3_read_done, ddr3_wr_data_req,
           ddr3_rd_data_valid, ddr3_rd_data,
    output ddr3_write_req, ddr3_read_req, ddr3_wr_addr, ddr3_rd_addr, ddr3_wr_data
  );

  modport slave (
    output ddr3_rdy, ddr3_write_done, ddr3_read_done, ddr3_wr_data_req,
           ddr3_rd_data_valid, ddr3_rd_data,
    input  ddr3_write_req, ddr3_read_req, ddr3_wr_addr, ddr3_rd_addr, ddr3_wr_data
  );
endinterface

// File: rtl/ddr3_traffic_gen.sv
// rtl/ddr3_traffic_gen.sv - DDR3 write/read-back traffic generator and checker with pass/error statistics
// Optional single-beat error injection is enabled by defining TRAFFIC_GEN_INJECT_EN.
module ddr3_traffic_gen #(
  parameter int DATA_W     = 512,
  parameter int ADDR_W     = 28,
  parameter int BURST_LEN  = 8,
  parameter int ADDR_STEP  = 8,
  parameter int NUM_BURSTS = 16
) (
  input  logic              i_app_clk,
  input  logic              i_app_rst,
  input  logic              i_start,
  input  logic              i_loop,
  input  logic              i_stop,
  input  logic [1:0]        i_mode,
  input  logic [31:0]       i_seed,
  input  logic [ADDR_W-1:0] i_base_addr,
`ifdef TRAFFIC_GEN_INJECT_EN
  input  logic              i_inject_err,
`endif
  ddr3_traffic_gen_if.master io_ddr3,
  output logic              o_busy,
  output logic              o_done,
  output logic [15:0]       o_pass_cnt,
  output logic [15:0]       o_err_cnt,
  output logic              o_err_flag,
  output logic [ADDR_W-1:0] o_first_err_addr
);

  localparam int LANES = DATA_W / 32;
  localparam logic [31:0] BL32 = 32'(BURST_LEN);
  localparam logic [31:0] LAST_BURST = 32'(NUM_BURSTS - 1);
  localparam logic [ADDR_W-1:0] BURST_STRIDE = ADDR_W'(BURST_LEN * ADDR_STEP);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_WAIT, S_WR_REQ, S_RD_WAIT, S_RD_REQ, S_PASS_END
  } state_t;

  state_t r_state, w_next;

  logic [1:0]        r_mode;
  logic [31:0]       r_seed;
  logic [ADDR_W-1:0] r_base;
  logic [31:0]       r_burst;
  logic [31:0]       r_wr_b, r_wr_lfsr;
  logic [31:0]       r_rd_b, r_rd_lfsr, r_rd_cnt;
  logic              r_stop_lat;
  logic              r_wr_req, r_rd_req;
  logic [ADDR_W-1:0] r_wr_addr, r_rd_addr;
  logic              r_busy, r_done;
  logic [15:0]       r_pass_cnt, r_err_cnt;
  logic              r_err_flag;
  logic [ADDR_W-1:0] r_first_err_addr;

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
  endfunction

  function automatic logic [31:0] lfsr_adv(input logic [31:0] x, input logic [31:0] n);
    logic [31:0] v;
    v = x;
    for (int i = 0; i < BURST_LEN; i++)
      if (32'(i) < n) v = lfsr_step(v);
    return v;
  endfunction

  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base, input logic [31:0] b);
    return base + ADDR_W'(b * 32'(ADDR_STEP));
  endfunction

  function automatic logic [DATA_W-1:0] pattern(input logic [1:0] mode, input logic [31:0] seed,
                                                input logic [31:0] b, input logic [31:0] lfsr,
                                                input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int k = 0; k < LANES; k++) begin
      case (mode)
        2'd0:    d[k*32 +: 32] = seed + b;
        2'd1:    d[k*32 +: 32] = 32'(addr) + 32'(k);
        2'd2:    d[k*32 +: 32] = lfsr;
        default: d[k*32 +: 32] = b[0] ? 32'hAAAA_AAAA : 32'h5555_5555;
      endcase
    end
    return d;
  endfunction

  logic              w_wr_take, w_rd_accept, w_rd_done, w_mismatch, w_err_any;
  logic [31:0]       w_rcvd, w_missing, w_err_sum;
  logic [15:0]       w_err_next;
  logic [ADDR_W-1:0] w_rd_beat_addr;
  logic [DATA_W-1:0] w_wr_pattern, w_rd_expect;

  assign w_wr_pattern   = pattern(r_mode, r_seed, r_wr_b, r_wr_lfsr, beat_addr(r_base, r_wr_b));
  assign w_wr_take      = io_ddr3.ddr3_wr_data_req && (r_state == S_WR_WAIT || r_state == S_WR_REQ);
  assign w_rd_beat_addr = beat_addr(r_base, r_rd_b);
  assign w_rd_expect    = pattern(r_mode, r_seed, r_rd_b, r_rd_lfsr, w_rd_beat_addr);
  // Beats beyond BURST_LEN in a burst are dropped so they cannot shift the expected sequence
  assign w_rd_accept    = io_ddr3.ddr3_rd_data_valid && r_state == S_RD_REQ && r_rd_cnt < BL32;
  assign w_rd_done      = io_ddr3.ddr3_read_done && r_state == S_RD_REQ;
  assign w_mismatch     = w_rd_accept && (io_ddr3.ddr3_rd_data != w_rd_expect);
  assign w_rcvd         = r_rd_cnt + 32'(w_rd_accept);
  assign w_missing      = (w_rd_done && w_rcvd < BL32) ? BL32 - w_rcvd : 32'd0;
  assign w_err_any      = w_mismatch || (w_missing != 32'd0);
  assign w_err_sum      = 32'(r_err_cnt) + 32'(w_mismatch) + w_missing;
  assign w_err_next     = (w_err_sum > 32'h0000_FFFF) ? 16'hFFFF : w_err_sum[15:0];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (i_start) w_next = S_WR_WAIT;
      S_WR_WAIT:  if (io_ddr3.ddr3_rdy) w_next = S_WR_REQ;
      S_WR_REQ:   if (io_ddr3.ddr3_write_done) w_next = (r_burst == LAST_BURST) ? S_RD_WAIT : S_WR_WAIT;
      S_RD_WAIT:  if (io_ddr3.ddr3_rdy) w_next = S_RD_REQ;
      S_RD_REQ:   if (io_ddr3.ddr3_read_done) w_next = (r_burst == LAST_BURST) ? S_PASS_END : S_RD_WAIT;
      S_PASS_END: w_next = (i_loop && !r_stop_lat && !i_stop) ? S_WR_WAIT : S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_app_clk) begin
    if (i_app_rst) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  always_ff @(posedge i_app_clk) begin
    if (i_app_rst) begin
      r_mode <= '0; r_seed <= '0; r_base <= '0; r_burst <= '0;
      r_wr_b <= '0; r_wr_lfsr <= '0; r_rd_b <= '0; r_rd_lfsr <= '0; r_rd_cnt <= '0;
      r_stop_lat <= 1'b0; r_wr_req <= 1'b0; r_rd_req <= 1'b0;
      r_wr_addr <= '0; r_rd_addr <= '0; r_busy <= 1'b0; r_done <= 1'b0;
      r_pass_cnt <= '0; r_err_cnt <= '0; r_err_flag <= 1'b0; r_first_err_addr <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (i_start) begin
          r_mode <= i_mode; r_seed <= i_seed; r_base <= i_base_addr;
          r_burst <= '0; r_wr_b <= '0; r_wr_lfsr <= i_seed;
          r_rd_b <= '0; r_rd_cnt <= '0; r_stop_lat <= 1'b0; r_busy <= 1'b1;
          r_pass_cnt <= '0; r_err_cnt <= '0; r_err_flag <= 1'b0; r_first_err_addr <= '0;
        end
        S_WR_WAIT: if (io_ddr3.ddr3_rdy) begin
          r_wr_req  <= 1'b1;
          r_wr_addr <= r_base + ADDR_W'(r_burst) * BURST_STRIDE;
        end
        S_WR_REQ: if (io_ddr3.ddr3_write_done) begin
          r_wr_req <= 1'b0;
          if (r_burst == LAST_BURST) begin
            r_burst <= '0; r_rd_b <= '0; r_rd_lfsr <= r_seed; r_rd_cnt <= '0;
          end else begin
            r_burst <= r_burst + 32'd1;
          end
        end
        S_RD_WAIT: if (io_ddr3.ddr3_rdy) begin
          r_rd_req  <= 1'b1;
          r_rd_addr <= r_base + ADDR_W'(r_burst) * BURST_STRIDE;
        end
        S_RD_REQ: if (io_ddr3.ddr3_read_done) begin
          r_rd_req <= 1'b0;
          r_burst  <= r_burst + 32'd1;
        end
        S_PASS_END: begin
          r_pass_cnt <= r_pass_cnt + 16'd1;
          if (i_loop && !r_stop_lat && !i_stop) begin
            r_burst <= '0; r_wr_b <= '0; r_wr_lfsr <= r_seed;
          end else begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase

      if (i_stop && r_busy) r_stop_lat <= 1'b1;

      if (w_wr_take) begin
        r_wr_b    <= r_wr_b + 32'd1;
        r_wr_lfsr <= lfsr_step(r_wr_lfsr);
      end

      if (w_rd_accept) begin
        r_rd_b    <= r_rd_b + 32'd1;
        r_rd_lfsr <= lfsr_step(r_rd_lfsr);
        r_rd_cnt  <= r_rd_cnt + 32'd1;
      end
      // A short burst jumps the checker to the first beat of the next burst
      if (w_rd_done) begin
        r_rd_b    <= r_rd_b + 32'(w_rd_accept) + w_missing;
        r_rd_lfsr <= lfsr_adv(w_rd_accept ? lfsr_step(r_rd_lfsr) : r_rd_lfsr, w_missing);
        r_rd_cnt  <= '0;
      end

      if (w_err_any) begin
        r_err_cnt  <= w_err_next;
        r_err_flag <= 1'b1;
        if (!r_err_flag)
          r_first_err_addr <= w_mismatch ? w_rd_beat_addr
                                         : beat_addr(r_base, r_rd_b + 32'(w_rd_accept));
      end
    end
  end

`ifdef TRAFFIC_GEN_INJECT_EN
  logic r_inj_arm;

  always_ff @(posedge i_app_clk) begin
    if (i_app_rst)                   r_inj_arm <= 1'b0;
    else if (i_inject_err)           r_inj_arm <= 1'b1;
    else if (w_wr_take && r_inj_arm) r_inj_arm <= 1'b0;
  end

  assign io_ddr3.ddr3_wr_data = w_wr_pattern ^ {{(DATA_W-1){1'b0}}, r_inj_arm};
`else
  assign io_ddr3.ddr3_wr_data = w_wr_pattern;
`endif

  assign io_ddr3.ddr3_write_req = r_wr_req;
  assign io_ddr3.ddr3_read_req  = r_rd_req;
  assign io_ddr3.ddr3_wr_addr   = r_wr_addr;
  assign io_ddr3.ddr3_rd_addr   = r_rd_addr;
  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_pass_cnt       = r_pass_cnt;
  assign o_err_cnt        = r_err_cnt;
  assign o_err_flag       = r_err_flag;
  assign o_first_err_addr = r_first_err_addr;

endmodule

// File: tb/tb_ddr3_traffic_gen.sv
// tb/tb_ddr3_traffic_gen.sv - directed self-checking bench for ddr3_traffic_gen with a behavioural DDR3_manage model
module tb_ddr3_traffic_gen;

  localparam int DW = 128;
  localparam int AW = 28;
  localparam int BL = 8;

  logic          clk, rst;
  logic          start, loop_en, stop;
  logic [1:0]    mode;
  logic [31:0]   seed;
  logic [AW-1:0] base;
`ifdef TRAFFIC_GEN_INJECT_EN
  logic          inject;
`endif
  logic          busy, done, err_flag;
  logic [15:0]   pass_cnt, err_cnt;
  logic [AW-1:0] first_err_addr;

  int n_cmp = 0;
  int n_mis = 0;

  int corrupt_burst = -1;
  int corrupt_beat  = 0;
  int short_burst   = -1;
  int short_n       = BL;
  int rd_burst_ctr  = 0;

  logic [DW-1:0] mem [logic [AW-1:0]];

  ddr3_traffic_gen_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  ddr3_traffic_gen #(
    .DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL), .ADDR_STEP(8), .NUM_BURSTS(4)
  ) dut (
    .i_app_clk(clk), .i_app_rst(rst),
    .i_start(start), .i_loop(loop_en), .i_stop(stop),
    .i_mode(mode), .i_seed(seed), .i_base_addr(base),
`ifdef TRAFFIC_GEN_INJECT_EN
    .i_inject_err(inject),
`endif
    .io_ddr3(bus),
    .o_busy(busy), .o_done(done), .o_pass_cnt(pass_cnt), .o_err_cnt(err_cnt),
    .o_err_flag(err_flag), .o_first_err_addr(first_err_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural DDR3_manage: ideal memory with per-read-burst corruption and short-burst knobs
  initial begin
    logic [AW-1:0] a, k;
    int nb;
    bus.ddr3_wr_data_req = 1'b0; bus.ddr3_write_done = 1'b0; bus.ddr3_read_done = 1'b0;
    bus.ddr3_rd_data_valid = 1'b0; bus.ddr3_rd_data = '0;
    forever begin
      @(negedge clk);
      if (!busy) rd_burst_ctr = 0;
      if (bus.ddr3_write_req) begin
        a = bus.ddr3_wr_addr;
        for (int i = 0; i < BL; i++) begin
          bus.ddr3_wr_data_req = 1'b1;
          k = a + AW'(i * 8);
          mem[k] = bus.ddr3_wr_data;
          @(negedge clk);
        end
        bus.ddr3_wr_data_req = 1'b0; bus.ddr3_write_done = 1'b1;
        @(negedge clk);
        bus.ddr3_write_done = 1'b0;
      end else if (bus.ddr3_read_req) begin
        a  = bus.ddr3_rd_addr;
        nb = (rd_burst_ctr == short_burst) ? short_n : BL;
        for (int i = 0; i < nb; i++) begin
          k = a + AW'(i * 8);
          bus.ddr3_rd_data_valid = 1'b1;
          bus.ddr3_rd_data = mem.exists(k) ? mem[k] : '0;
          if (rd_burst_ctr == corrupt_burst && i == corrupt_beat)
            bus.ddr3_rd_data = bus.ddr3_rd_data ^ {{(DW-17){1'b0}}, 17'h1_0000};
          @(negedge clk);
        end
        bus.ddr3_rd_data_valid = 1'b0; bus.ddr3_rd_data = '0; bus.ddr3_read_done = 1'b1;
        @(negedge clk);
        bus.ddr3_read_done = 1'b0;
        rd_burst_ctr++;
      end
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mem_chk(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    logic [DW-1:0] v;
    v = mem.exists(a) ? mem[a] : 'x;
    chk(tag, v, exp);
  endtask

  task automatic pulse_start(input logic [1:0] m, input logic [31:0] s, input logic [AW-1:0] b);
    mode = m; seed = s; base = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    chk(tag, done, 1'b1);
  endtask

  task automatic wait_pass(input string tag, input logic [15:0] cnt);
    int n = 0;
    while (pass_cnt !== cnt && n < 5000) begin @(negedge clk); n++; end
    chk(tag, pass_cnt, cnt);
  endtask

  task automatic wait_wr_req(input string tag);
    int n = 0;
    while (bus.ddr3_write_req !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    chk(tag, bus.ddr3_write_req, 1'b1);
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_pass_cnt"}, pass_cnt, 0);
    chk({pfx, "_err_cnt"}, err_cnt, 0);
    chk({pfx, "_err_flag"}, err_flag, 0);
    chk({pfx, "_first_err_addr"}, first_err_addr, 0);
    chk({pfx, "_wr_req"}, bus.ddr3_write_req, 0);
    chk({pfx, "_rd_req"}, bus.ddr3_read_req, 0);
    chk({pfx, "_wr_data"}, bus.ddr3_wr_data, 0);
    chk({pfx, "_wr_addr"}, bus.ddr3_wr_addr, 0);
    chk({pfx, "_rd_addr"}, bus.ddr3_rd_addr, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; loop_en = 1'b0; stop = 1'b0;
    mode = 2'd0; seed = '0; base = '0;
    bus.ddr3_rdy = 1'b1;
`ifdef TRAFFIC_GEN_INJECT_EN
    inject = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // mode 0, seed 0x10: lanes 0x10..0x2F; no request while manager is not ready
    bus.ddr3_rdy = 1'b0;
    pulse_start(2'd0, 32'h10, 28'h000_1000);
    chk("t1_busy_after_start", busy, 1);
    repeat (3) @(negedge clk);
    chk("t1_no_req_without_rdy", bus.ddr3_write_req, 0);
    bus.ddr3_rdy = 1'b1;
    wait_done("t1_done");
    chk("t1_pass_cnt", pass_cnt, 1);
    chk("t1_err_cnt", err_cnt, 0);
    chk("t1_err_flag", err_flag, 0);
    chk("t1_busy_low", busy, 0);
    mem_chk("t1_beat0", 28'h000_1000, {4{32'h0000_0010}});
    mem_chk("t1_beat31", 28'h000_10F8, {4{32'h0000_002F}});

    // mode 1 with the region wrapping through address 0
    @(negedge clk);
    pulse_start(2'd1, 32'h0, 28'hFFF_FFC0);
    wait_done("t2_done");
    chk("t2_err_cnt", err_cnt, 0);
    mem_chk("t2_beat0", 28'hFFF_FFC0, {32'h0FFF_FFC3, 32'h0FFF_FFC2, 32'h0FFF_FFC1, 32'h0FFF_FFC0});
    mem_chk("t2_burst1_wrapped", 28'h000_0000, {32'h3, 32'h2, 32'h1, 32'h0});
    mem_chk("t2_burst2", 28'h000_0040, {32'h43, 32'h42, 32'h41, 32'h40});

    // read beat 5 of burst 1 corrupted
    @(negedge clk);
    corrupt_burst = 1; corrupt_beat = 5;
    pulse_start(2'd0, 32'h100, 28'h000_2000);
    wait_done("t3_done");
    corrupt_burst = -1;
    chk("t3_err_cnt", err_cnt, 1);
    chk("t3_first_err_addr", first_err_addr, 28'h000_2068);
    chk("t3_err_flag", err_flag, 1);
    chk("t3_pass_cnt", pass_cnt, 1);

    // LFSR pattern with first read burst returning 6 of 8 beats
    @(negedge clk);
    short_burst = 0; short_n = 6;
    pulse_start(2'd2, 32'h0000_ACE1, 28'h000_3000);
    wait_done("t4_done");
    short_burst = -1;
    chk("t4_err_cnt", err_cnt, 2);
    chk("t4_pass_cnt", pass_cnt, 1);
    mem_chk("t4_lfsr_beat0", 28'h000_3000, {4{32'h0000_ACE1}});
    mem_chk("t4_lfsr_beat1", 28'h000_3008, {4{32'h0001_59C3}});

    // alternating 0x55/0xAA pattern
    @(negedge clk);
    pulse_start(2'd3, 32'h0, 28'h000_5000);
    wait_done("t5_done");
    chk("t5_err_cnt", err_cnt, 0);
    mem_chk("t5_even", 28'h000_5000, {4{32'h5555_5555}});
    mem_chk("t5_odd", 28'h000_5008, {4{32'hAAAA_AAAA}});

    // looping LFSR test stopped during pass 3
    @(negedge clk);
    loop_en = 1'b1;
    pulse_start(2'd2, 32'h1234, 28'h000_4000);
    wait_pass("t6_reach_pass2", 16'd2);
    chk("t6_busy_looping", busy, 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_done("t6_done");
    loop_en = 1'b0;
    chk("t6_pass_cnt", pass_cnt, 3);
    chk("t6_err_cnt", err_cnt, 0);
    chk("t6_busy_low", busy, 0);

`ifdef TRAFFIC_GEN_INJECT_EN
    @(negedge clk);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    pulse_start(2'd0, 32'h0, 28'h000_6000);
    wait_done("inj_done");
    chk("inj_err_cnt", err_cnt, 1);
    chk("inj_first_err_addr", first_err_addr, 28'h000_6000);
`endif

    // reset in the middle of a write burst of pass 2
    @(negedge clk);
    loop_en = 1'b1;
    corrupt_burst = 0; corrupt_beat = 0;
    pulse_start(2'd0, 32'h0, 28'h000_7000);
    wait_pass("t7_reach_pass1", 16'd1);
    chk("t7_err_before_reset", err_cnt, 1);
    wait_wr_req("t7_wr_req");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_all_zero("t7_rst");
    @(negedge clk);
    rst = 1'b0; loop_en = 1'b0; corrupt_burst = -1;
    repeat (30) @(negedge clk);
    chk("t7_idle_busy", busy, 0);
    chk("t7_idle_wr_req", bus.ddr3_write_req, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
